// File: rtl/sub16_serial.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first, start/done handshake.
// Optional signed-overflow output `ovf` when SUB16_SERIAL_OVF_EN is defined.
module sub16_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUB16_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count;
  logic             borrow_r;

`ifdef SUB16_SERIAL_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  // One full-subtractor bit slice on the current LSBs
  logic             a0_c;
  logic             b0_c;
  logic             d_c;
  logic             borrow_nxt_c;
  logic [WIDTH-1:0] res_nxt_c;

  assign a0_c         = sa[0];
  assign b0_c         = sb[0];
  assign d_c          = a0_c ^ b0_c ^ borrow_r;
  assign borrow_nxt_c = (~a0_c & b0_c) | (~(a0_c ^ b0_c) & borrow_r);
  assign res_nxt_c    = {d_c, res[WIDTH-1:1]};

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      res      <= '0;
      count    <= '0;
      borrow_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
`ifdef SUB16_SERIAL_OVF_EN
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE (back-to-back)
        IDLE, DONE: begin
          if (start) begin
            sa       <= a;
            sb       <= b;
            res      <= '0;
            count    <= '0;
            borrow_r <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
`ifdef SUB16_SERIAL_OVF_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        SHIFT: begin
          res      <= res_nxt_c;
          sa       <= sa >> 1;
          sb       <= sb >> 1;
          borrow_r <= borrow_nxt_c;
          count    <= count + CW'(1);
          // Final bit: publish the result so it is valid during the DONE cycle
          if (count == LAST_BIT) begin
            state  <= DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            diff   <= res_nxt_c;
            borrow <= borrow_nxt_c;
`ifdef SUB16_SERIAL_OVF_EN
            ovf    <= (a_msb != b_msb) && (d_c != a_msb);
`endif
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub16_serial.sv
// Directed self-checking bench for sub16_serial (define SUB16_SERIAL_OVF_EN to also check ovf).
module tb_sub16_serial;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        borrow;
`ifdef SUB16_SERIAL_OVF_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;

  sub16_serial #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SUB16_SERIAL_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge and count edges until done is seen (bounded)
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, output int n);
    @(negedge clk);
    a = av; b = bv; start = 1'b1; n = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff: got %h want 0000", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow); end
`ifdef SUB16_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    @(negedge clk);
    a = 16'd28; b = 16'd10; start = 1'b1; n = 0;
    @(posedge clk); #1; start = 1'b0; n = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b want 1", busy); end
    do begin
      @(posedge clk); #1; n++;
    end while (!done && n < 40);
    checks++; if (n !== 17) begin errors++; $display("FAIL basic_latency: got %0d want 17", n); end
    checks++; if (diff !== 16'd18) begin errors++; $display("FAIL basic_diff: got %h want 0012", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b want 0", borrow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (diff !== 16'd18) begin errors++; $display("FAIL basic_diff_hold: got %h want 0012", diff); end
  endtask

  task automatic test_borrow;
    int n;
    run_op(16'd10, 16'd20, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL neg_latency: got %0d want 17", n); end
    checks++; if (diff !== 16'hFFF6) begin errors++; $display("FAIL neg_diff: got %h want fff6", diff); end
    checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL neg_borrow: got %b want 1", borrow); end
`ifdef SUB16_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL neg_ovf: got %b want 0", ovf); end
`endif
    run_op(16'h0000, 16'h0001, n);
    checks++; if (diff !== 16'hFFFF) begin errors++; $display("FAIL zero_minus_one_diff: got %h want ffff", diff); end
    checks++; if (borrow !== 1'b1) begin errors++; $display("FAIL zero_minus_one_borrow: got %b want 1", borrow); end
`ifdef SUB16_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL zero_minus_one_ovf: got %b want 0", ovf); end
`endif
    run_op(16'h8000, 16'h0001, n);
    checks++; if (diff !== 16'h7FFF) begin errors++; $display("FAIL min_minus_one_diff: got %h want 7fff", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL min_minus_one_borrow: got %b want 0", borrow); end
`ifdef SUB16_SERIAL_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL min_minus_one_ovf: got %b want 1", ovf); end
`endif
  endtask

  task automatic test_back_to_back;
    int n;
    int busy_bad;
    busy_bad = 0;
    @(negedge clk);
    a = 16'd20; b = 16'd20; start = 1'b1; n = 0;
    @(posedge clk); #1; n = 1;
    a = 16'd28; b = 16'd20;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk); #1; n++;
    end
    checks++; if (n !== 17) begin errors++; $display("FAIL b2b_first_latency: got %0d want 17", n); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL b2b_first_diff: got %h want 0000", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL b2b_first_borrow: got %b want 0", borrow); end
    @(posedge clk); #1; start = 1'b0; n = 1;
    while (!done && n < 40) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk); #1; n++;
    end
    checks++; if (n !== 17) begin errors++; $display("FAIL b2b_second_latency: got %0d want 17", n); end
    checks++; if (diff !== 16'd8) begin errors++; $display("FAIL b2b_second_diff: got %h want 0008", diff); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL b2b_busy_low_cycles: got %0d want 0", busy_bad); end
  endtask

  task automatic test_ignore_start;
    int n;
    @(negedge clk);
    a = 16'd100; b = 16'd1; start = 1'b1; n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) start = 1'b0;
      if (n == 5) begin a = 16'd5; b = 16'd50; start = 1'b1; end
      if (n == 6) begin
        start = 1'b0;
        checks++; if (diff !== 16'd8) begin errors++; $display("FAIL ignore_diff_held: got %h want 0008", diff); end
      end
    end while (!done && n < 40);
    checks++; if (n !== 17) begin errors++; $display("FAIL ignore_latency: got %0d want 17", n); end
    checks++; if (diff !== 16'd99) begin errors++; $display("FAIL ignore_diff: got %h want 0063", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL ignore_borrow: got %b want 0", borrow); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_extra_op: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL midrst_diff: got %h want 0000", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL midrst_borrow: got %b want 0", borrow); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd1, 16'd1, n);
    checks++; if (n !== 17) begin errors++; $display("FAIL after_rst_latency: got %0d want 17", n); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL after_rst_diff: got %h want 0000", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL after_rst_borrow: got %b want 0", borrow); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
